// File: rtl/ui_button_conditioner.sv
// Debounces five active-low pushbuttons and eight slide switches; buttons emit one-cycle press pulses, up/down auto-repeat while held.
// Latency: DEBOUNCE_CYCLES+1 edges from first raw sample to registered output; no backpressure, every output is a free-running register.
module ui_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 650000,
    parameter int REPEAT_DELAY    = 13500000,
    parameter int REPEAT_RATE     = 2700000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_enter_raw,
    input  logic       btn_up_raw,
    input  logic       btn_down_raw,
    input  logic       btn_left_raw,
    input  logic       btn_right_raw,
    input  logic [7:0] sw_raw,
    output logic       enter,
    output logic       up,
    output logic       down,
    output logic       left,
    output logic       right,
    output logic       s7,
    output logic       s6,
    output logic       s5,
    output logic       s4,
    output logic       s3,
    output logic       s2,
    output logic       s1,
    output logic       s0
);

    localparam int NCH  = 13;
    localparam int NBTN = 5;
    localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

    localparam logic [DW-1:0]  DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0]  RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0]  RR_LAST = RW'(REPEAT_RATE - 1);
    // Released level per channel: buttons idle high, switches idle low.
    localparam logic [NCH-1:0] IDLE    = {8'h00, 5'b11111};

    // Channel order: 0 enter, 1 up, 2 down, 3 left, 4 right, 5..12 sw[0..7].
    logic [NCH-1:0]  raw;
    logic [NCH-1:0]  meta_q;
    logic [NCH-1:0]  sync_q;
    logic [NCH-1:0]  deb_q, deb_d;
    logic [DW-1:0]   cnt_q [NCH];
    logic [DW-1:0]   cnt_d [NCH];
    logic [NBTN-1:0] pulse_q, pulse_d;
    logic [1:0]      rfirst_q, rfirst_d;
    logic [RW-1:0]   rcnt_q [2];
    logic [RW-1:0]   rcnt_d [2];

    assign raw = {sw_raw, btn_right_raw, btn_left_raw, btn_down_raw, btn_up_raw, btn_enter_raw};

    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = '0;
            if (sync_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    deb_d[i] = sync_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end

        pulse_d = deb_q[NBTN-1:0] & ~deb_d[NBTN-1:0];

        // Repeat timer only runs while up/down is pressed before and after this edge.
        for (int j = 0; j < 2; j++) begin
            rcnt_d[j]   = '0;
            rfirst_d[j] = 1'b1;
            if (!deb_q[j+1] && !deb_d[j+1]) begin
                rfirst_d[j] = rfirst_q[j];
                if (rcnt_q[j] == (rfirst_q[j] ? RD_LAST : RR_LAST)) begin
                    pulse_d[j+1] = 1'b1;
                    rfirst_d[j]  = 1'b0;
                end else begin
                    rcnt_d[j] = rcnt_q[j] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q   <= IDLE;
            sync_q   <= IDLE;
            deb_q    <= IDLE;
            pulse_q  <= '0;
            rfirst_q <= 2'b11;
            for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
            for (int j = 0; j < 2; j++) rcnt_q[j] <= '0;
        end else begin
            meta_q   <= raw;
            sync_q   <= meta_q;
            deb_q    <= deb_d;
            pulse_q  <= pulse_d;
            rfirst_q <= rfirst_d;
            for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
            for (int j = 0; j < 2; j++) rcnt_q[j] <= rcnt_d[j];
        end
    end

    assign {right, left, down, up, enter}      = pulse_q;
    assign {s7, s6, s5, s4, s3, s2, s1, s0}    = deb_q[NCH-1:NBTN];

endmodule

// File: tb/tb_ui_button_conditioner.sv
// Directed bench for ui_button_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_RATE=3.
// Edge k is the k-th rising edge after an input change; outputs are sampled 1 time unit after it.
module tb_ui_button_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_enter_raw, btn_up_raw, btn_down_raw, btn_left_raw, btn_right_raw;
    logic [7:0] sw_raw;
    logic       enter, up, down, left, right;
    logic       s7, s6, s5, s4, s3, s2, s1, s0;

    int checks = 0;
    int errors = 0;

    ui_button_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (8),
        .REPEAT_RATE    (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_enter_raw(btn_enter_raw),
        .btn_up_raw   (btn_up_raw),
        .btn_down_raw (btn_down_raw),
        .btn_left_raw (btn_left_raw),
        .btn_right_raw(btn_right_raw),
        .sw_raw       (sw_raw),
        .enter        (enter),
        .up           (up),
        .down         (down),
        .left         (left),
        .right        (right),
        .s7           (s7),
        .s6           (s6),
        .s5           (s5),
        .s4           (s4),
        .s3           (s3),
        .s2           (s2),
        .s1           (s1),
        .s0           (s0)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Button bits are {enter, up, down, left, right}.
    task automatic check(input string tag, input logic [4:0] exp_btn, input logic [7:0] exp_sw);
        logic [4:0] got_btn;
        logic [7:0] got_sw;
        got_btn = {enter, up, down, left, right};
        got_sw  = {s7, s6, s5, s4, s3, s2, s1, s0};
        checks++;
        assert (got_btn === exp_btn) else begin
            errors++;
            $error("FAIL %s buttons got %b want %b", tag, got_btn, exp_btn);
        end
        checks++;
        assert (got_sw === exp_sw) else begin
            errors++;
            $error("FAIL %s switches got %h want %h", tag, got_sw, exp_sw);
        end
    endtask

    initial begin
        reset = 1'b0;
        {btn_enter_raw, btn_up_raw, btn_down_raw, btn_left_raw, btn_right_raw} = 5'b11111;
        sw_raw = 8'h00;
        step();
        step();
        check("reset_idle", 5'b0, 8'h00);

        // Active inputs while reset is held must not reach any output.
        {btn_enter_raw, btn_up_raw, btn_down_raw, btn_left_raw, btn_right_raw} = 5'b00000;
        sw_raw = 8'hFF;
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("reset_hold k%0d", k), 5'b0, 8'h00);
        end
        {btn_enter_raw, btn_up_raw, btn_down_raw, btn_left_raw, btn_right_raw} = 5'b11111;
        sw_raw = 8'h00;
        step();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("idle k%0d", k), 5'b0, 8'h00);
        end

        // Clean enter press held long enough to prove enter never repeats.
        btn_enter_raw = 1'b0;
        for (int k = 0; k < 21; k++) begin
            step();
            check($sformatf("enter_press k%0d", k), (k == 5) ? 5'b10000 : 5'b0, 8'h00);
        end
        btn_enter_raw = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            check($sformatf("enter_release k%0d", k), 5'b0, 8'h00);
        end

        // Left bounces high at edge 3; final falling sample at edge 4.
        for (int k = 0; k < 15; k++) begin
            btn_left_raw = (k == 3);
            step();
            check($sformatf("left_bounce k%0d", k), (k == 9) ? 5'b00010 : 5'b0, 8'h00);
        end
        btn_left_raw = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("left_release k%0d", k), 5'b0, 8'h00);
        end

        // Up held: P=5, repeats at 13, 16, 19, 22; raw release at edge 18 debounces at 23.
        for (int k = 0; k < 36; k++) begin
            btn_up_raw = (k >= 18);
            step();
            check($sformatf("up_repeat k%0d", k),
                  (k == 5 || k == 13 || k == 16 || k == 19 || k == 22) ? 5'b01000 : 5'b0, 8'h00);
        end
        // Re-press restarts from the single-press timing.
        for (int k = 0; k < 21; k++) begin
            btn_up_raw = (k >= 6);
            step();
            check($sformatf("up_repress k%0d", k), (k == 5) ? 5'b01000 : 5'b0, 8'h00);
        end

        // Down and right fall together.
        for (int k = 0; k < 16; k++) begin
            btn_down_raw  = (k >= 6);
            btn_right_raw = (k >= 6);
            step();
            check($sformatf("down_right k%0d", k), (k == 5) ? 5'b00101 : 5'b0, 8'h00);
        end

        // Switch 2 on, 2-cycle glitch at edges 10-11, off from edge 20.
        for (int k = 0; k < 30; k++) begin
            sw_raw = (k == 10 || k == 11 || k >= 20) ? 8'h00 : 8'h04;
            step();
            check($sformatf("switch k%0d", k), 5'b0, (k >= 5 && k < 25) ? 8'h04 : 8'h00);
        end

        // Reset lands with the enter counter at 2; button stays held throughout.
        btn_enter_raw = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("rst_pre k%0d", k), 5'b0, 8'h00);
        end
        reset = 1'b0;
        #1;
        check("rst_async", 5'b0, 8'h00);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("rst_mid k%0d", k), 5'b0, 8'h00);
        end
        reset = 1'b1;
        for (int k = 0; k < 11; k++) begin
            step();
            check($sformatf("rst_post k%0d", k), (k == 5) ? 5'b10000 : 5'b0, 8'h00);
        end
        btn_enter_raw = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("rst_release k%0d", k), 5'b0, 8'h00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
